// File: rtl/multicycle_sequencer.sv
// Multicycle LEGv8 sequencer: FETCH, then a variable number of EXEC phases, with HALT/resume.
// Optional SEQ_STALL_CNT_EN: counts EXEC stall cycles and FETCH wait cycles in stall_count.
module multicycle_sequencer #(
  parameter int MAX_EX  = 4,
  parameter int PHASE_W = 2,
  parameter int CNT_W   = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [31:0]        instr_in,
  input  logic               mem_ready,
  input  logic [PHASE_W:0]   ex_len,
  input  logic               ex_mem,
  input  logic               halt_req,
  input  logic               resume,
  output logic [31:0]        ir,
  output logic [PHASE_W-1:0] phase,
  output logic               in_fetch,
  output logic               mem_req,
  output logic               il,
  output logic               retire,
  output logic               halted,
  output logic [CNT_W-1:0]   retired_count,
  output logic [CNT_W-1:0]   stall_count
);

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    EXEC  = 2'b01,
    HALT  = 2'b10
  } state_t;

  localparam logic [PHASE_W:0] LP_MAX = (PHASE_W+1)'(MAX_EX);
  localparam logic [PHASE_W:0] LP_ONE = (PHASE_W+1)'(1);

  state_t             r_state, w_state_nxt;
  logic [PHASE_W-1:0] r_phase, w_phase_nxt;
  logic [31:0]        r_ir;
  logic [CNT_W-1:0]   r_retired;
  logic [PHASE_W:0]   w_len;
  logic               w_last;
  logic               w_stall;

  // Effective length: zero counts as one phase, oversize lengths clamp to MAX_EX.
  always_comb begin
    w_len = ex_len;
    if (ex_len == '0)
      w_len = LP_ONE;
    else if (ex_len > LP_MAX)
      w_len = LP_MAX;
  end

  assign w_last  = ({1'b0, r_phase} == (w_len - LP_ONE));
  assign w_stall = (r_state == EXEC) && ex_mem && !mem_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    mem_req     = 1'b0;
    il          = 1'b0;
    retire      = 1'b0;
    case (r_state)
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          il          = 1'b1;
          w_phase_nxt = '0;
          w_state_nxt = EXEC;
        end else if (halt_req) begin
          w_state_nxt = HALT;
        end
      end
      EXEC: begin
        mem_req = ex_mem;
        if (!w_stall) begin
          if (!w_last) begin
            w_phase_nxt = r_phase + 1'b1;
          end else begin
            retire      = 1'b1;
            w_phase_nxt = '0;
            w_state_nxt = halt_req ? HALT : FETCH;
          end
        end
      end
      HALT: begin
        if (resume)
          w_state_nxt = FETCH;
      end
      default: begin
        w_state_nxt = FETCH;
        w_phase_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= FETCH;
      r_phase   <= '0;
      r_ir      <= '0;
      r_retired <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
      if (il)
        r_ir <= instr_in;
      if (retire)
        r_retired <= r_retired + 1'b1;
    end
  end

`ifdef SEQ_STALL_CNT_EN
  logic             w_fetch_wait;
  logic [CNT_W-1:0] r_stall_cnt;

  assign w_fetch_wait = (r_state == FETCH) && !mem_ready && !halt_req;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      r_stall_cnt <= '0;
    else if (w_stall || w_fetch_wait)
      r_stall_cnt <= r_stall_cnt + 1'b1;
  end

  assign stall_count = r_stall_cnt;
`else
  assign stall_count = '0;
`endif

  assign ir            = r_ir;
  assign phase         = r_phase;
  assign in_fetch      = (r_state == FETCH);
  assign halted        = (r_state == HALT);
  assign retired_count = r_retired;

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Parametrised state sequencer for the multicycle LEGv8 datapath. It generalises the fixed IF/EX0/EX1/EX2 state register into a fetch phase plus a variable number of execute phases per instruction.
- Adds a memory ready handshake with stall, halt/resume control and a retired-instruction counter.
- Sits between instruction memory and the control-word decode logic. The decode logic consumes `ir` and `phase` and returns the phase count and the memory-wait flag.

Parameters:
- MAX_EX, 4: maximum execute phases per instruction (>=1).
- PHASE_W, 2: width of the phase index; must satisfy 2^PHASE_W >= MAX_EX.
- CNT_W, 32: width of the retired and stall counters.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- instr_in  input  32  instruction word from memory; valid when mem_ready=1 in FETCH.
- mem_ready  input  1  memory handshake; completes a fetch or a memory execute phase.
- ex_len  input  PHASE_W+1  execute phase count for the held `ir`; combinational from decode.
- ex_mem  input  1  current execute phase is a memory access and must wait for mem_ready.
- halt_req  input  1  level request to stop at the next instruction boundary.
- resume  input  1  leave HALT.
- ir  output  32  instruction register.
- phase  output  PHASE_W  current execute phase index; 0 outside EXEC.
- in_fetch  output  1  state == FETCH.
- mem_req  output  1  memory request, combinational.
- il  output  1  instruction load strobe, combinational.
- retire  output  1  one-cycle pulse on an instruction's final phase.
- halted  output  1  state == HALT.
- retired_count  output  CNT_W  instructions retired since reset.
- stall_count  output  CNT_W  stall cycles; see Optional Feature.

Behaviour:
- States: FETCH, EXEC, HALT, 2-bit encoded.
- Reset (reset=0, asynchronous): state=FETCH, ir=0, phase=0, retired_count=0, stall_count=0. All registered outputs are 0 and in_fetch=1.
- FETCH:
  - mem_req=1.
  - If halt_req=1 and mem_ready=0: go to HALT next cycle. No fetch is consumed.
  - If mem_ready=1: il=1 in that cycle; ir<=instr_in; phase<=0; go to EXEC. This happens even if halt_req=1, because a completed fetch always executes.
  - Otherwise stay in FETCH.
- EXEC:
  - mem_req = ex_mem.
  - Effective length L = max(1, min(ex_len, MAX_EX)). ex_len=0 is treated as 1; ex_len>MAX_EX is clamped.
  - Stall: if ex_mem=1 and mem_ready=0, hold state and phase. No retire.
  - Otherwise, if phase < L-1: phase <= phase+1.
  - Otherwise (last phase): retire=1 this cycle; retired_count increments and wraps at 2^CNT_W; phase<=0. Next state is HALT if halt_req=1, else FETCH.
- HALT:
  - mem_req=0.
  - If resume=1: go to FETCH next cycle. halt_req is ignored in the resume cycle.
  - Otherwise stay in HALT.
- Latency: fetch-to-retire is 1 fetch cycle + L execute cycles + stall cycles. The minimum instruction is 2 cycles.
- ir changes only on an il cycle. phase is 0 whenever state != EXEC.
- Reset asserted mid-EXEC or mid-stall aborts immediately, with no retire pulse and no counter update.
- mem_ready outside a request (HALT, or EXEC with ex_mem=0) is ignored.

Optional Feature:
- Macro: SEQ_STALL_CNT_EN.
- Defined: stall_count increments on every EXEC stall cycle and every FETCH cycle with mem_ready=0 and halt_req=0. It wraps and resets to 0.
- Undefined: stall_count is tied to 0 and no counter register is synthesised.

Test Plan:
- Basic fetch/execute: with mem_ready=1 constant and ex_len=3, run two instructions 0x8B020020 and 0x91000421. Expect il in cycles 0 and 4, retire in cycles 3 and 7, retired_count=2, and phase sequence 0,1,2.
- Execute stall: ex_len=2 and ex_mem=1 in phase 1, with mem_ready held low for 3 cycles. Expect phase to hold at 1 for 3 cycles, a single retire afterwards, and stall_count=3 when the macro is on (0 when off).
- Length boundaries: ex_len=0 gives 1 phase (retire in the cycle after il). ex_len=7 with MAX_EX=4 gives exactly 4 phases.
- Halt handling:
  - halt_req raised during EXEC of a 2-phase instruction: expect retire, then halted=1 and mem_req=0.
  - resume pulse: expect FETCH the next cycle.
  - halt_req with mem_ready=0 in FETCH: expect HALT with ir unchanged.
- Asynchronous reset: drive reset=0 mid-stall in phase 2. Expect all outputs to reset without waiting for a clock edge, no retire pulse, and in_fetch=1 after release.
- Counter wrap: with CNT_W=4, retiring 17 instructions gives retired_count=1.
